code_lock_ctrl: RTL and testbench

Sequencing controller around the 4-bit equality datapath driven by the `no`/`push1`/`push2` switch inputs. It turns single-digit compares into a multi-digit combination lock:
- programs a DIGITS-long code through `push1`;
- checks an entered sequence through `push2`, one digit per press;
- drives `ledpin` on a full match;
- counts failed attempts and enforces a timed lockout.

It sits between the board switches/buttons and the LED outputs.

---
 rtl/code_lock_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_code_lock_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: multi-digit combination lock built around a 4-bit digit compare.
// push1 programs a DIGITS-long code, push2 enters one digit per press.
// ledpin shows a full match, errpin pulses once for a failed attempt.
// armed shows that a complete code is stored.
// Optional feature macro LOCKOUT_EN adds failure counting and a timed lockout (LOCK state, lockpin).
// Without LOCKOUT_EN a failed attempt only pulses errpin, and lockpin is tied low.
`timescale 1ns/1ps
module code_lock_ctrl #(
    parameter int DIGITS      = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] no,
    input  logic       push1,
    input  logic       push2,
    output logic       ledpin,
    output logic       errpin,
    output logic       lockpin,
    output logic       armed
);

    localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);
    // An out-of-range configuration never accepts a code, so it can never arm.
    localparam bit CFG_OK = (DIGITS >= 1) && (DIGITS <= 7) && (MAX_FAIL >= 1) &&
                            (MAX_FAIL <= 7) && (LOCK_CYCLES >= 1);
`ifdef LOCKOUT_EN
    localparam int             LW         = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LW-1:0]  LOCK_LAST  = LW'(LOCK_CYCLES - 1);
    localparam logic [2:0]     FAIL_LIMIT = 3'(MAX_FAIL);
`endif

    typedef enum logic [2:0] {
        IDLE,
        PROG,
        ENTER,
`ifdef LOCKOUT_EN
        LOCK,
`endif
        OPEN
    } state_t;

    state_t     state_reg;
    logic [2:0] idx_reg;
    logic       miss_reg;
    logic       code_valid_reg;
    logic       ledpin_reg;
    logic       errpin_reg;
`ifdef LOCKOUT_EN
    logic [2:0]    fail_cnt_reg;
    logic [LW-1:0] lock_cnt_reg;
    logic          lockpin_reg;
`endif
    logic       p1_q;
    logic       p2_q;

    logic [3:0] code_rd [DIGITS];
    logic       rise1;
    logic       rise2;
    logic       ev1;
    logic       ev2;
    logic       prog_ev;
    logic       entry_ev;
    logic [2:0] code_widx;
    logic [3:0] cmp_digit;
    logic       new_miss;
    logic       last_digit;

    // Previous-cycle button levels for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_q <= 1'b0;
            p2_q <= 1'b0;
        end else begin
            p1_q <= push1;
            p2_q <= push2;
        end
    end

    // Button events, digit write selection and the compare against the stored digit.
    always_comb begin
        rise1    = push1 & ~p1_q;
        rise2    = push2 & ~p2_q;
        // Simultaneous presses are ambiguous, so both are dropped.
        ev1      = rise1 & ~rise2;
        ev2      = rise2 & ~rise1;
        prog_ev  = CFG_OK && ev1 &&
                   ((state_reg == IDLE && !code_valid_reg) ||
                    state_reg == PROG || state_reg == OPEN);
        entry_ev = ev2 && ((state_reg == IDLE && code_valid_reg) || state_reg == ENTER);
        // A fresh programming run (from IDLE or OPEN) always starts at digit 0.
        code_widx = (state_reg == PROG) ? idx_reg : 3'd0;
        cmp_digit = code_rd[0];
        for (int i = 1; i < DIGITS; i++) begin
            if (idx_reg == 3'(i)) begin
                cmp_digit = code_rd[i];
            end
        end
        // idx is 0 in IDLE, so the first digit compares against code[0].
        new_miss   = ((state_reg == ENTER) ? miss_reg : 1'b0) | (no != cmp_digit);
        last_digit = (idx_reg == LAST_IDX);
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] digit_reg;

            // One stored code digit, written when programming reaches its position.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    digit_reg <= 4'd0;
                end else if (prog_ev && code_widx == 3'(gi)) begin
                    digit_reg <= no;
                end
            end

            assign code_rd[gi] = digit_reg;
        end
    endgenerate

    // Sequencing FSM with registered indicator outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            idx_reg        <= 3'd0;
            miss_reg       <= 1'b0;
            code_valid_reg <= 1'b0;
            ledpin_reg     <= 1'b0;
            errpin_reg     <= 1'b0;
`ifdef LOCKOUT_EN
            fail_cnt_reg   <= 3'd0;
            lock_cnt_reg   <= '0;
            lockpin_reg    <= 1'b0;
`endif
        end else begin
            errpin_reg <= 1'b0;
            if (entry_ev) begin
                if (!last_digit) begin
                    miss_reg  <= new_miss;
                    idx_reg   <= idx_reg + 3'd1;
                    state_reg <= ENTER;
                end else begin
                    // Attempt complete: resolve it and rewind for the next one.
                    miss_reg <= 1'b0;
                    idx_reg  <= 3'd0;
                    if (!new_miss) begin
                        ledpin_reg <= 1'b1;
                        state_reg  <= OPEN;
`ifdef LOCKOUT_EN
                        fail_cnt_reg <= 3'd0;
`endif
                    end else begin
                        errpin_reg <= 1'b1;
`ifdef LOCKOUT_EN
                        fail_cnt_reg <= fail_cnt_reg + 3'd1;
                        if (fail_cnt_reg + 3'd1 == FAIL_LIMIT) begin
                            lock_cnt_reg <= '0;
                            lockpin_reg  <= 1'b1;
                            state_reg    <= LOCK;
                        end else begin
                            state_reg <= IDLE;
                        end
`else
                        state_reg <= IDLE;
`endif
                    end
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (prog_ev) begin
                            if (DIGITS == 1) begin
                                code_valid_reg <= 1'b1;
                            end else begin
                                idx_reg   <= 3'd1;
                                state_reg <= PROG;
                            end
                        end
                    end
                    PROG: begin
                        if (prog_ev) begin
                            if (last_digit) begin
                                code_valid_reg <= 1'b1;
                                idx_reg        <= 3'd0;
                                state_reg      <= IDLE;
                            end else begin
                                idx_reg <= idx_reg + 3'd1;
                            end
                        end
                    end
                    ENTER: begin
                        // Digits are consumed through entry_ev; push1 is ignored here.
                    end
                    OPEN: begin
                        if (ev2) begin
                            ledpin_reg <= 1'b0;
                            state_reg  <= IDLE;
                        end else if (prog_ev) begin
                            // Reprogram: digit 0 is captured on this press.
                            ledpin_reg <= 1'b0;
                            if (DIGITS == 1) begin
                                state_reg <= IDLE;
                            end else begin
                                code_valid_reg <= 1'b0;
                                idx_reg        <= 3'd1;
                                state_reg      <= PROG;
                            end
                        end
                    end
`ifdef LOCKOUT_EN
                    LOCK: begin
                        if (lock_cnt_reg == LOCK_LAST) begin
                            fail_cnt_reg <= 3'd0;
                            lockpin_reg  <= 1'b0;
                            state_reg    <= IDLE;
                        end else begin
                            lock_cnt_reg <= lock_cnt_reg + 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ledpin = ledpin_reg;
    assign errpin = errpin_reg;
    assign armed  = code_valid_reg;
`ifdef LOCKOUT_EN
    assign lockpin = lockpin_reg;
`else
    assign lockpin = 1'b0;
`endif

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl (DIGITS=4, MAX_FAIL=3, LOCK_CYCLES=16).
// Expectations follow the LOCKOUT_EN setting of the build.
`timescale 1ns/1ps
module tb_code_lock_ctrl;

`ifdef LOCKOUT_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] no = 4'd0;
    logic       push1 = 1'b0;
    logic       push2 = 1'b0;
    logic       ledpin;
    logic       errpin;
    logic       lockpin;
    logic       armed;

    int tests_run = 0;
    int tests_failed = 0;
    int lock_hi_cnt = 0;
    int lock_base;

    always #5 clk = ~clk;

    code_lock_ctrl #(
        .DIGITS      (4),
        .MAX_FAIL    (3),
        .LOCK_CYCLES (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .no      (no),
        .push1   (push1),
        .push2   (push2),
        .ledpin  (ledpin),
        .errpin  (errpin),
        .lockpin (lockpin),
        .armed   (armed)
    );

    // Count every cycle lockpin is observed high.
    always @(negedge clk) begin
        if (lockpin) lock_hi_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One press: high for one sampled edge, then released; returns at the negedge after the acting edge.
    task automatic press1(input logic [3:0] d);
        @(negedge clk);
        no = d;
        push1 = 1'b1;
        @(negedge clk);
        push1 = 1'b0;
        $display("[TB] push1 no=%h led=%b err=%b lock=%b armed=%b", d, ledpin, errpin, lockpin, armed);
    endtask

    task automatic press2(input logic [3:0] d);
        @(negedge clk);
        no = d;
        push2 = 1'b1;
        @(negedge clk);
        push2 = 1'b0;
        $display("[TB] push2 no=%h led=%b err=%b lock=%b armed=%b", d, ledpin, errpin, lockpin, armed);
    endtask

    task automatic hold2(input logic [3:0] d, input int n);
        @(negedge clk);
        no = d;
        push2 = 1'b1;
        repeat (n) @(negedge clk);
        push2 = 1'b0;
        $display("[TB] push2 held %0d cycles no=%h led=%b", n, d, ledpin);
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        press2(a);
        press2(b);
        press2(c);
        press2(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_led", ledpin, 0);
        check("rst_err", errpin, 0);
        check("rst_lock", lockpin, 0);
        check("rst_armed", armed, 0);

        // Program A3F0
        press1(4'hA);
        press1(4'h3);
        press1(4'hF);
        check("prog3_armed", armed, 0);
        press1(4'h0);
        check("prog4_armed", armed, 1);

        // Correct entry unlocks
        press2(4'hA);
        press2(4'h3);
        press2(4'hF);
        check("ent3_led", ledpin, 0);
        press2(4'h0);
        check("ent4_led", ledpin, 1);
        check("ent4_err", errpin, 0);
        press2(4'h5);
        check("open_exit_led", ledpin, 0);

        // Wrong digit then correct entry
        enter4(4'hA, 4'h3, 4'hE, 4'h0);
        check("wrong_err", errpin, 1);
        check("wrong_led", ledpin, 0);
        @(negedge clk);
        check("wrong_err_1cyc", errpin, 0);
        enter4(4'hA, 4'h3, 4'hF, 4'h0);
        check("retry_led", ledpin, 1);
        press2(4'h0);

        // Three failures -> lockout
        lock_base = lock_hi_cnt;
        enter4(4'h1, 4'h3, 4'hF, 4'h0);
        check("f1_err", errpin, 1);
        check("f1_lock", lockpin, 0);
        enter4(4'hA, 4'h1, 4'hF, 4'h0);
        check("f2_lock", lockpin, 0);
        enter4(4'hA, 4'h3, 4'hF, 4'h1);
        check("f3_err", errpin, 1);
        check("f3_lock", lockpin, LK);
        enter4(4'hA, 4'h3, 4'hF, 4'h0);
        check("lock_ignore_led", ledpin, !LK);
        check("lock_still", lockpin, LK);
        if (!LK) press2(4'h0);
        for (int i = 0; i < 40 && lockpin; i++) @(negedge clk);
        check("lock_release", lockpin, 0);
        #1;
        check("lock_len", lock_hi_cnt - lock_base, LK ? 16 : 0);
        enter4(4'hA, 4'h3, 4'hF, 4'h0);
        check("post_lock_led", ledpin, 1);
        press2(4'h0);
        enter4(4'hA, 4'h3, 4'hF, 4'h2);
        check("post_lock_fail_err", errpin, 1);
        check("post_lock_fail_lock", lockpin, 0);

        // Held push2 counts once
        hold2(4'hA, 10);
        press2(4'h3);
        press2(4'hF);
        press2(4'h0);
        check("held_led", ledpin, 1);
        press2(4'h0);

        // Simultaneous rise ignored, push1 while armed ignored
        @(negedge clk);
        no = 4'hA;
        push1 = 1'b1;
        push2 = 1'b1;
        @(negedge clk);
        push1 = 1'b0;
        push2 = 1'b0;
        $display("[TB] push1+push2 no=A led=%b err=%b armed=%b", ledpin, errpin, armed);
        check("both_armed", armed, 1);
        check("both_err", errpin, 0);
        press1(4'h5);
        check("p1_idle_armed", armed, 1);
        enter4(4'hA, 4'h3, 4'hF, 4'h0);
        check("hyg_led", ledpin, 1);

        // Reprogram from OPEN to 1234
        press1(4'h1);
        check("rep1_armed", armed, 0);
        check("rep1_led", ledpin, 0);
        press1(4'h2);
        press1(4'h3);
        press1(4'h4);
        check("rep4_armed", armed, 1);
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        check("new_code_led", ledpin, 1);
        press2(4'h0);
        enter4(4'hA, 4'h3, 4'hF, 4'h0);
        check("old_code_err", errpin, 1);
        check("old_code_led", ledpin, 0);

        // Asynchronous reset mid-entry
        press2(4'h1);
        press2(4'h2);
        #2 reset = 1'b1;
        #1;
        $display("[TB] async reset mid-entry armed=%b led=%b", armed, ledpin);
        check("arst_armed", armed, 0);
        check("arst_led", ledpin, 0);
        @(negedge clk);
        reset = 1'b0;
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        check("arst_ignored_err", errpin, 0);
        check("arst_ignored_led", ledpin, 0);
        check("arst_ignored_armed", armed, 0);
        press1(4'h7);
        press1(4'h7);
        press1(4'h0);
        press1(4'h1);
        check("reprog_armed", armed, 1);
        enter4(4'h7, 4'h7, 4'h0, 4'h1);
        check("reprog_led", ledpin, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
